uart_bus_master: RTL and testbench
==================================

UART_BUS_MASTER -- requirements
Module: uart_bus_master

Interface
REQ-001 Parameter READ_LATENCY, default 1: cycles from the bus_en cycle to the cycle in which bus_din is valid; legal range 1..15.
REQ-002 Parameter TIMEOUT, default 1000000: maximum idle clk cycles between bytes of one command; legal range 2..2^24-1.
REQ-003 clk  input  1  sole clock; every port is synchronous to it.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 s_valid  input  1  byte available from the UART receive FIFO.
REQ-006 s_data  input  8  received byte.
REQ-007 s_ready  output  1  byte consumed when s_valid & s_ready are both high on a rising clk edge.
REQ-008 m_valid  output  1  response byte offered to the UART transmit FIFO.
REQ-009 m_data  output  8  response byte.
REQ-010 m_ready  input  1  transmit FIFO accepts m_data when m_valid & m_ready are both high on a rising clk edge.
REQ-011 bus_addr  output  32  bus address, held stable from the bus_en cycle through data capture.
REQ-012 bus_dout  output  32  bus write data.
REQ-013 bus_we  output  4  byte write enables; 4'hF on a write, 4'h0 on a read.
REQ-014 bus_en  output  1  single-cycle bus access strobe.
REQ-015 bus_din  input  32  bus read data.

Function
REQ-016 The block SHALL be a UART command initiator. It parses host bytes into bus accesses and returns the results as bytes.
REQ-017 Protocol: 'W'(0x57) + 4 address bytes + 4 data bytes is a write, answered with 'K'(0x4B). 'R'(0x52) + 4 address bytes is a read, answered with 4 data bytes. All multi-byte fields are sent MSB first.
REQ-018 States SHALL be IDLE, ADDR, DATA, ACCESS, WAIT, RESP.
REQ-019 IDLE: s_ready=1. A 'W' or 'R' SHALL latch the command type, clear the byte counter and go to ADDR. Any other byte SHALL be dropped, and the state stays IDLE.
REQ-020 ADDR: s_ready=1. Each accepted byte SHALL shift into bus_addr ({addr[23:0],byte}). On the 4th byte, go to DATA for a write or ACCESS for a read.
REQ-021 DATA: s_ready=1. Each accepted byte SHALL shift into bus_dout the same way. On the 4th byte, go to ACCESS.
REQ-022 ACCESS: bus_en=1 for exactly one cycle, with bus_we=4'hF (write) or 4'h0 (read). A write then loads response {8'h4B} with count 1 and goes to RESP. A read goes to WAIT.
REQ-023 WAIT: after READ_LATENCY cycles counted from the ACCESS cycle, bus_din SHALL be captured into the 32-bit response register with count 4, and the state goes to RESP.
REQ-024 RESP: s_ready=0, m_valid=1, m_data=response[31:24] (write response stored in [31:24]). On each handshake, shift left 8 and decrement the count. On the last byte, return to IDLE.
REQ-025 s_ready SHALL be 0 in ACCESS, WAIT and RESP. Incoming bytes are back-pressured, never dropped, while a command executes.
REQ-026 bus_en SHALL be 0 in every state except ACCESS. bus_we SHALL be 0 whenever bus_en is 0.
REQ-027 Timeout: in ADDR or DATA, a counter SHALL clear on every accepted byte and increment on every other cycle.
REQ-028 If the timeout counter reaches TIMEOUT, the block SHALL return to IDLE with no bus access and no response.
REQ-029 m_valid SHALL NOT drop and m_data SHALL NOT change while m_valid=1 and m_ready=0.
REQ-030 Each command SHALL produce exactly one bus access. Back-to-back commands with no idle cycles between bytes SHALL be supported.

Reset
REQ-031 While rst=1 the block SHALL hold: state IDLE, s_ready=0, m_valid=0, m_data=0, bus_en=0, bus_we=0, bus_addr=0, bus_dout=0, all counters 0.
REQ-032 rst asserted in any state, including mid-command or mid-response, SHALL abort the command. Any partial response is discarded and no further bus access occurs.
REQ-033 In the first cycle after rst deasserts, s_ready SHALL be 1.

Verification
REQ-034 Write: bytes 57 12 34 56 78 DE AD BE EF -> one bus_en cycle with addr=0x12345678, dout=0xDEADBEEF, we=F; then m_data=4B.
REQ-035 Read: with READ_LATENCY=1 and bus_din=0xCAFEF00D one cycle after bus_en, bytes 52 00 00 00 10 -> bus_en with addr=0x10, we=0; then m_data CA,FE,F0,0D.
REQ-036 Garbage: bytes 00 FF 41 then a valid read -> no bus access for the first three bytes; the read completes normally.
REQ-037 Timeout: TIMEOUT=16; send 57 01 02, then stall 16 cycles -> return to IDLE, no bus_en. A following 52 00 00 00 00 is processed as a read.
REQ-038 Back-pressure: hold m_ready=0 for 10 cycles during a read response -> m_data stays CA and s_ready=0; all 4 bytes are delivered in order after release.
REQ-039 Reset: assert rst after the 2nd response byte -> m_valid=0 next cycle, no further bytes; s_ready=1 after release.

Source files
------------

// File: rtl/uart_bus_master.sv
// UART command initiator: parses 'W'/'R' frames from the receive byte stream,
// performs one 32-bit bus access per frame and streams the response bytes back.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a command byte; other bytes are dropped
// ADDR   | collecting 4 address bytes, MSB first
// DATA   | collecting 4 write-data bytes, MSB first
// ACCESS | single-cycle bus strobe
// WAIT   | counting read latency until bus_din is valid
// RESP   | offering response bytes to the transmit FIFO
module uart_bus_master #(
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT      = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        m_valid,
  output logic [7:0]  m_data,
  input  logic        m_ready,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_dout,
  output logic [3:0]  bus_we,
  output logic        bus_en,
  input  logic [31:0] bus_din
);

  localparam logic [7:0]  CMD_WRITE = 8'h57;
  localparam logic [7:0]  CMD_READ  = 8'h52;
  localparam logic [7:0]  RESP_OK   = 8'h4B;
  localparam logic [23:0] TO_LAST   = 24'(TIMEOUT - 1);
  localparam logic [3:0]  LAT_LOAD  = 4'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    ACCESS,
    WAIT,
    RESP
  } stateT;

  stateT       state;
  stateT       stateNext;
  logic        isWrite;
  logic [1:0]  byteCnt;
  logic [23:0] toCnt;
  logic [3:0]  latCnt;
  logic [31:0] respReg;
  logic [2:0]  respCnt;
  logic        isCmd;

  assign isCmd = (s_data == CMD_WRITE) || (s_data == CMD_READ);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state decode and handshake/bus outputs; everything is forced quiet during reset.
  always_comb begin
    stateNext = state;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    m_data    = 8'h00;
    bus_en    = 1'b0;
    bus_we    = 4'h0;
    if (!rst) begin
      case (state)
        IDLE: begin
          s_ready = 1'b1;
          if (s_valid && isCmd) begin
            stateNext = ADDR;
          end
        end
        ADDR: begin
          s_ready = 1'b1;
          if (s_valid) begin
            if (byteCnt == 2'd3) begin
              stateNext = isWrite ? DATA : ACCESS;
            end
          end else if (toCnt == TO_LAST) begin
            stateNext = IDLE;
          end
        end
        DATA: begin
          s_ready = 1'b1;
          if (s_valid) begin
            if (byteCnt == 2'd3) begin
              stateNext = ACCESS;
            end
          end else if (toCnt == TO_LAST) begin
            stateNext = IDLE;
          end
        end
        ACCESS: begin
          bus_en    = 1'b1;
          bus_we    = isWrite ? 4'hF : 4'h0;
          stateNext = isWrite ? RESP : WAIT;
        end
        WAIT: begin
          if (latCnt == 4'd0) begin
            stateNext = RESP;
          end
        end
        RESP: begin
          m_valid = 1'b1;
          m_data  = respReg[31:24];
          if (m_ready && (respCnt == 3'd1)) begin
            stateNext = IDLE;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // Datapath: field shifting, inter-byte timeout, read latency and response shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      isWrite  <= 1'b0;
      byteCnt  <= 2'd0;
      toCnt    <= 24'd0;
      latCnt   <= 4'd0;
      respReg  <= 32'd0;
      respCnt  <= 3'd0;
      bus_addr <= 32'd0;
      bus_dout <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (s_valid && isCmd) begin
            isWrite <= (s_data == CMD_WRITE);
            byteCnt <= 2'd0;
            toCnt   <= 24'd0;
          end
        end
        ADDR: begin
          if (s_valid) begin
            bus_addr <= {bus_addr[23:0], s_data};
            byteCnt  <= byteCnt + 2'd1;
            toCnt    <= 24'd0;
          end else begin
            toCnt <= toCnt + 24'd1;
          end
        end
        DATA: begin
          if (s_valid) begin
            bus_dout <= {bus_dout[23:0], s_data};
            byteCnt  <= byteCnt + 2'd1;
            toCnt    <= 24'd0;
          end else begin
            toCnt <= toCnt + 24'd1;
          end
        end
        ACCESS: begin
          if (isWrite) begin
            respReg <= {RESP_OK, 24'h000000};
            respCnt <= 3'd1;
          end else begin
            latCnt <= LAT_LOAD;
          end
        end
        WAIT: begin
          if (latCnt == 4'd0) begin
            respReg <= bus_din;
            respCnt <= 3'd4;
          end else begin
            latCnt <= latCnt - 4'd1;
          end
        end
        RESP: begin
          if (m_ready) begin
            respReg <= {respReg[23:0], 8'h00};
            respCnt <= respCnt - 3'd1;
          end
        end
        default: begin
          respCnt <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Self-checking bench for uart_bus_master: directed frames plus randomized
// command streams scored against a frame-level reference model.
module tb_uart_bus_master;

  localparam int RL = 1;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready = 1'b0;
  logic [31:0] bus_addr;
  logic [31:0] bus_dout;
  logic [3:0]  bus_we;
  logic        bus_en;
  logic [31:0] bus_din = 32'h0;

  uart_bus_master #(.READ_LATENCY(RL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_we(bus_we),
    .bus_en(bus_en), .bus_din(bus_din)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef logic [7:0] byteQ[$];
  typedef struct {
    logic [31:0] addr;
    logic [31:0] dout;
    bit          isWr;
  } accT;

  int errCnt = 0;
  int chkCnt = 0;

  accT         expAccQ[$];
  logic [7:0]  expRxQ[$];
  logic [31:0] refMem[logic [31:0]];
  logic [31:0] slaveMem[logic [31:0]];

  int          cycNum = 0;
  int          readDue = -1;
  logic [31:0] readVal = 32'h0;
  int          rxCnt = 0;
  int          accCnt = 0;
  int          readyMode = 0;
  logic        prevHeld = 1'b0;
  logic [7:0]  prevData = 8'h00;
  accT         curAcc;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memInit(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : memInit(a);
  endfunction

  // Cycle counter used to schedule read data.
  always @(posedge clk) cycNum <= cycNum + 1;

  // Transmit-side sink, bus slave and per-cycle protocol monitor.
  always @(negedge clk) begin
    case (readyMode)
      0:       m_ready = 1'b1;
      1:       m_ready = ($urandom_range(0, 3) != 0);
      default: m_ready = 1'b0;
    endcase
    if (!rst) begin
      if (prevHeld) begin
        checkVal("hold_valid", 32'(m_valid), 32'd1);
        checkVal("hold_data", 32'(m_data), 32'(prevData));
      end
      if (!bus_en) checkVal("we_without_en", 32'(bus_we), 32'd0);
      if (m_valid) checkVal("s_ready_in_resp", 32'(s_ready), 32'd0);
      if (bus_en) begin
        accCnt++;
        checkVal("access_expected", 32'(expAccQ.size() > 0), 32'd1);
        if (expAccQ.size() > 0) begin
          curAcc = expAccQ.pop_front();
          checkVal("acc_addr", bus_addr, curAcc.addr);
          checkVal("acc_we", 32'(bus_we), curAcc.isWr ? 32'hF : 32'h0);
          if (curAcc.isWr) checkVal("acc_dout", bus_dout, curAcc.dout);
        end
        if (bus_we == 4'hF) begin
          slaveMem[bus_addr] = bus_dout;
        end else begin
          readDue = cycNum + RL;
          readVal = slaveMem.exists(bus_addr) ? slaveMem[bus_addr] : memInit(bus_addr);
        end
      end
      if (m_valid && m_ready) begin
        rxCnt++;
        checkVal("rx_expected", 32'(expRxQ.size() > 0), 32'd1);
        if (expRxQ.size() > 0) checkVal("rx_byte", 32'(m_data), 32'(expRxQ.pop_front()));
      end
      prevHeld = m_valid && !m_ready;
      prevData = m_data;
    end else begin
      prevHeld = 1'b0;
    end
    bus_din = (cycNum == readDue) ? readVal : $urandom;
  end

  task automatic sendByte(input logic [7:0] b);
    int n = 0;
    forever begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = b;
      if (s_ready) break;
      n++;
      if (n > 500) begin
        checkVal("wait_s_ready", 32'(s_ready), 32'd1);
        break;
      end
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_data  = 8'($urandom);
    end
  endtask

  function automatic byteQ buildFrame(input bit isWr, input logic [31:0] addr, input logic [31:0] data);
    byteQ q;
    q.push_back(isWr ? 8'h57 : 8'h52);
    for (int i = 3; i >= 0; i--) q.push_back(addr[i*8 +: 8]);
    if (isWr) for (int i = 3; i >= 0; i--) q.push_back(data[i*8 +: 8]);
    return q;
  endfunction

  task automatic pushExpect(input bit isWr, input logic [31:0] addr, input logic [31:0] data);
    accT e;
    logic [31:0] v;
    e.addr = addr;
    e.dout = data;
    e.isWr = isWr;
    expAccQ.push_back(e);
    if (isWr) begin
      refMem[addr] = data;
      expRxQ.push_back(8'h4B);
    end else begin
      v = refRead(addr);
      for (int i = 3; i >= 0; i--) expRxQ.push_back(v[i*8 +: 8]);
    end
  endtask

  task automatic sendFrame(input byteQ fr, input int gapPct, input int stallIdx, input int stallLen);
    for (int i = 0; i < fr.size(); i++) begin
      sendByte(fr[i]);
      if (i == stallIdx) idleCycles(stallLen);
      else if (($urandom_range(0, 99) < gapPct) && (i != fr.size() - 1)) idleCycles($urandom_range(1, 5));
    end
  endtask

  task automatic waitDrain(input int limit);
    int n = 0;
    while ((expRxQ.size() != 0 || expAccQ.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkVal("drain_rx", 32'(expRxQ.size()), 32'd0);
    checkVal("drain_acc", 32'(expAccQ.size()), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    checkVal({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    checkVal({tag, "_m_data"}, 32'(m_data), 32'd0);
    checkVal({tag, "_bus_en"}, 32'(bus_en), 32'd0);
    checkVal({tag, "_bus_we"}, 32'(bus_we), 32'd0);
    checkVal({tag, "_bus_addr"}, bus_addr, 32'd0);
    checkVal({tag, "_bus_dout"}, bus_dout, 32'd0);
  endtask

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errCnt, chkCnt);
    $fatal(1);
  end

  // Directed scenarios followed by a randomized command stream.
  initial begin
    int a0, r0, n;
    byteQ fr;
    bit isWr;
    logic [31:0] addr, data;
    logic [7:0] g;

    rst = 1'b1;
    readyMode = 0;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    @(negedge clk);
    checkVal("s_ready_after_reset", 32'(s_ready), 32'd1);

    // Write frame: 57 12 34 56 78 DE AD BE EF -> 4B
    pushExpect(1'b1, 32'h12345678, 32'hDEADBEEF);
    sendFrame(buildFrame(1'b1, 32'h12345678, 32'hDEADBEEF), 0, -1, 0);
    idleCycles(1);
    waitDrain(100);

    // Read frame with known bus data: CA FE F0 0D
    refMem[32'h10]   = 32'hCAFEF00D;
    slaveMem[32'h10] = 32'hCAFEF00D;
    pushExpect(1'b0, 32'h10, 32'h0);
    sendFrame(buildFrame(1'b0, 32'h10, 32'h0), 0, -1, 0);
    idleCycles(1);
    waitDrain(100);

    // Garbage bytes are dropped, following read completes
    a0 = accCnt;
    sendByte(8'h00);
    sendByte(8'hFF);
    sendByte(8'h41);
    idleCycles(3);
    checkVal("garbage_no_access", 32'(accCnt - a0), 32'd0);
    pushExpect(1'b0, 32'h10, 32'h0);
    sendFrame(buildFrame(1'b0, 32'h10, 32'h0), 0, -1, 0);
    idleCycles(1);
    waitDrain(100);
    checkVal("garbage_then_read", 32'(accCnt - a0), 32'd1);

    // Stall of TIMEOUT-1 cycles inside a frame is tolerated
    pushExpect(1'b1, 32'h01020304, 32'hA5A55A5A);
    sendFrame(buildFrame(1'b1, 32'h01020304, 32'hA5A55A5A), 0, 2, TO - 1);
    idleCycles(1);
    waitDrain(100);

    // Stall of TIMEOUT cycles aborts; next read parsed from scratch
    a0 = accCnt;
    r0 = rxCnt;
    sendByte(8'h57);
    sendByte(8'h01);
    sendByte(8'h02);
    idleCycles(TO);
    checkVal("timeout_no_access", 32'(accCnt - a0), 32'd0);
    pushExpect(1'b0, 32'h0, 32'h0);
    sendFrame(buildFrame(1'b0, 32'h0, 32'h0), 0, -1, 0);
    idleCycles(1);
    waitDrain(100);
    checkVal("timeout_one_access", 32'(accCnt - a0), 32'd1);
    checkVal("timeout_rx_count", 32'(rxCnt - r0), 32'd4);

    // Back-pressure on the response
    readyMode = 2;
    pushExpect(1'b0, 32'h10, 32'h0);
    sendFrame(buildFrame(1'b0, 32'h10, 32'h0), 0, -1, 0);
    idleCycles(1);
    n = 0;
    while (!m_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkVal("bp_m_valid", 32'(m_valid), 32'd1);
    repeat (10) begin
      checkVal("bp_m_data", 32'(m_data), 32'hCA);
      checkVal("bp_s_ready", 32'(s_ready), 32'd0);
      @(negedge clk);
    end
    readyMode = 0;
    waitDrain(100);

    // Reset after the second response byte
    pushExpect(1'b0, 32'h10, 32'h0);
    sendFrame(buildFrame(1'b0, 32'h10, 32'h0), 0, -1, 0);
    idleCycles(1);
    r0 = rxCnt;
    n = 0;
    while ((rxCnt - r0) < 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    checkVal("rst_two_bytes_seen", 32'(rxCnt - r0), 32'd2);
    #1;
    rst = 1'b1;
    expRxQ.delete();
    expAccQ.delete();
    @(negedge clk);
    checkVal("rst_m_valid_next", 32'(m_valid), 32'd0);
    checkVal("rst_bus_en_next", 32'(bus_en), 32'd0);
    repeat (2) @(negedge clk);
    checkResetOutputs("midrsp_reset");
    rst = 1'b0;
    @(negedge clk);
    checkVal("s_ready_after_release", 32'(s_ready), 32'd1);
    r0 = rxCnt;
    a0 = accCnt;
    idleCycles(20);
    checkVal("rst_no_more_bytes", 32'(rxCnt - r0), 32'd0);
    checkVal("rst_no_more_access", 32'(accCnt - a0), 32'd0);

    // Randomized stream: garbage, aborted frames, back-to-back commands, random m_ready
    readyMode = 1;
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) begin
          do g = 8'($urandom); while (g == 8'h57 || g == 8'h52);
          sendByte(g);
        end
      end
      isWr = 1'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 15)) << 2;
      data = $urandom;
      fr = buildFrame(isWr, addr, data);
      if ($urandom_range(0, 9) == 0) begin
        n = $urandom_range(1, fr.size() - 1);
        while (fr.size() > n) void'(fr.pop_back());
        sendFrame(fr, 30, -1, 0);
        idleCycles(TO + $urandom_range(0, 3));
      end else begin
        pushExpect(isWr, addr, data);
        sendFrame(fr, 30, -1, 0);
        if ($urandom_range(0, 4) == 0) idleCycles($urandom_range(1, 4));
      end
    end
    idleCycles(1);
    waitDrain(4000);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
